// File: rtl/uart_packet_ctrl_if.sv
// Signal bundle between uart_packet_ctrl and its neighbours: the packet FIFOs, the UART byte engines and baudrategen.
// Byte handshake: a byte moves on a rising edge where byte_tx_valid & byte_tx_ready; valid never drops and data never changes until then.
interface uart_packet_ctrl_if #(
  parameter int usb_packet_width = 32,
  parameter int baud_sel_width   = 4
);
  logic [usb_packet_width-1:0] tx_data;
  logic                        tx_empty;
  logic                        tx_rden;
  logic                        tx_busy;
  logic [7:0]                  byte_tx_data;
  logic                        byte_tx_valid;
  logic                        byte_tx_ready;
  logic [7:0]                  byte_rx_data;
  logic                        byte_rx_valid;
  logic [usb_packet_width-1:0] rx_data;
  logic                        rx_full;
  logic                        rx_wren;
  logic                        rx_overrun;
  logic [baud_sel_width-1:0]   baud_sel;
  logic                        dbg_tx_state;
  logic [1:0]                  dbg_rx_cnt;

  modport master (
    input  tx_data, tx_empty, byte_tx_ready, byte_rx_data, byte_rx_valid, rx_full,
    output tx_rden, tx_busy, byte_tx_data, byte_tx_valid, rx_data, rx_wren, rx_overrun,
    output baud_sel, dbg_tx_state, dbg_rx_cnt
  );

  modport slave (
    output tx_data, tx_empty, byte_tx_ready, byte_rx_data, byte_rx_valid, rx_full,
    input  tx_rden, tx_busy, byte_tx_data, byte_tx_valid, rx_data, rx_wren, rx_overrun,
    input  baud_sel, dbg_tx_state, dbg_rx_cnt
  );
endinterface

// File: rtl/uart_packet_ctrl.sv
// Sequences USB packet FIFOs against the UART byte engines and owns the baud-select register.
// Optional config packets (bit 31 loads baud_sel) are built only when UART_PKT_CFG_EN is defined.
module uart_packet_ctrl #(
  parameter int usb_packet_width = 32,
  parameter int idle_timeout     = 1000,
  parameter int baud_sel_width   = 4,
  parameter int baud_sel_reset   = 0
) (
  input  logic               clk,
  input  logic               rst,
  uart_packet_ctrl_if.master io_bus
);
  localparam int TW = (idle_timeout > 2) ? $clog2(idle_timeout) : 1;
  localparam logic [TW-1:0] TMO = TW'(idle_timeout - 2);
  localparam logic [baud_sel_width-1:0] BAUD_RST = baud_sel_width'(baud_sel_reset);

  typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;

  tx_state_t   r_tx_state;
  logic [23:0] r_tx_pkt;
  logic [1:0]  r_tx_cnt;
  logic [1:0]  r_tx_idx;
  logic [7:0]  r_byte_tx_data;
  logic        r_byte_tx_valid;

  logic        w_tx_pop;
  logic        w_tx_cfg;
  logic        w_tx_last;
  logic [1:0]  w_tx_idx_nxt;
  logic [7:0]  w_tx_next;
  logic        w_unused_tx;

  assign w_tx_pop     = (r_tx_state == TX_IDLE) & ~io_bus.tx_empty;
  assign w_tx_last    = (r_tx_idx == r_tx_cnt - 2'd1);
  assign w_tx_idx_nxt = r_tx_idx + 2'd1;
  assign w_unused_tx  = ^io_bus.tx_data;

`ifdef UART_PKT_CFG_EN
  assign w_tx_cfg = io_bus.tx_data[31];
`else
  assign w_tx_cfg = 1'b0;
`endif

  always_comb begin
    w_tx_next = r_tx_pkt[7:0];
    case (w_tx_idx_nxt)
      2'd1:    w_tx_next = r_tx_pkt[15:8];
      2'd2:    w_tx_next = r_tx_pkt[23:16];
      default: w_tx_next = r_tx_pkt[7:0];
    endcase
  end

  // Empty and config packets are consumed in TX_IDLE, so the next pop can follow immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state      <= TX_IDLE;
      r_tx_pkt        <= '0;
      r_tx_cnt        <= '0;
      r_tx_idx        <= '0;
      r_byte_tx_data  <= '0;
      r_byte_tx_valid <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_pop && !w_tx_cfg && (io_bus.tx_data[25:24] != 2'd0)) begin
            r_tx_state      <= TX_SEND;
            r_tx_pkt        <= io_bus.tx_data[23:0];
            r_tx_cnt        <= io_bus.tx_data[25:24];
            r_tx_idx        <= 2'd0;
            r_byte_tx_data  <= io_bus.tx_data[7:0];
            r_byte_tx_valid <= 1'b1;
          end
        end
        TX_SEND: begin
          if (io_bus.byte_tx_ready) begin
            if (w_tx_last) begin
              r_tx_state      <= TX_IDLE;
              r_byte_tx_valid <= 1'b0;
            end else begin
              r_tx_idx       <= w_tx_idx_nxt;
              r_byte_tx_data <= w_tx_next;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

`ifdef UART_PKT_CFG_EN
  logic [baud_sel_width-1:0] r_baud_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_sel <= BAUD_RST;
    end else if (w_tx_pop && w_tx_cfg) begin
      r_baud_sel <= io_bus.tx_data[baud_sel_width-1:0];
    end
  end

  assign io_bus.baud_sel = r_baud_sel;
`else
  assign io_bus.baud_sel = BAUD_RST;
`endif

  logic [23:0]                 r_rx_acc;
  logic [1:0]                  r_rx_cnt;
  logic [TW-1:0]               r_rx_timer;
  logic                        r_pend;
  logic [usb_packet_width-1:0] r_pend_data;
  logic [usb_packet_width-1:0] r_rx_data;
  logic                        r_rx_wren;
  logic                        r_rx_overrun;

  logic [23:0]                 w_acc_upd;
  logic [1:0]                  w_cnt_upd;
  logic                        w_expire;
  logic                        w_flush;
  logic [usb_packet_width-1:0] w_pkt;

  always_comb begin
    w_acc_upd = r_rx_acc;
    w_cnt_upd = r_rx_cnt;
    if (io_bus.byte_rx_valid) begin
      case (r_rx_cnt)
        2'd0:    w_acc_upd[7:0]   = io_bus.byte_rx_data;
        2'd1:    w_acc_upd[15:8]  = io_bus.byte_rx_data;
        default: w_acc_upd[23:16] = io_bus.byte_rx_data;
      endcase
      w_cnt_upd = r_rx_cnt + 2'd1;
    end
  end

  // A byte landing on the expiry cycle is folded into the flushed packet.
  assign w_expire = (r_rx_cnt != 2'd0) && (r_rx_timer == TMO);
  assign w_flush  = (w_cnt_upd == 2'd3) || w_expire;

  always_comb begin
    w_pkt        = '0;
    w_pkt[23:0]  = w_acc_upd;
    w_pkt[25:24] = w_cnt_upd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_acc   <= '0;
      r_rx_cnt   <= '0;
      r_rx_timer <= '0;
    end else if (w_flush) begin
      r_rx_acc   <= '0;
      r_rx_cnt   <= '0;
      r_rx_timer <= '0;
    end else begin
      r_rx_acc <= w_acc_upd;
      r_rx_cnt <= w_cnt_upd;
      if (io_bus.byte_rx_valid || (r_rx_cnt == 2'd0)) r_rx_timer <= '0;
      else                                             r_rx_timer <= r_rx_timer + 1'b1;
    end
  end

  // The older pending packet always drains first; a fresh flush writes straight through when nothing waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend       <= 1'b0;
      r_pend_data  <= '0;
      r_rx_data    <= '0;
      r_rx_wren    <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_wren    <= 1'b0;
      r_rx_overrun <= 1'b0;
      if (r_pend && !io_bus.rx_full) begin
        r_rx_wren <= 1'b1;
        r_rx_data <= r_pend_data;
        r_pend    <= w_flush;
        if (w_flush) r_pend_data <= w_pkt;
      end else if (r_pend) begin
        if (w_flush) r_rx_overrun <= 1'b1;
      end else if (w_flush) begin
        if (!io_bus.rx_full) begin
          r_rx_wren <= 1'b1;
          r_rx_data <= w_pkt;
        end else begin
          r_pend      <= 1'b1;
          r_pend_data <= w_pkt;
        end
      end
    end
  end

  assign io_bus.tx_rden       = w_tx_pop;
  assign io_bus.tx_busy       = (r_tx_state == TX_SEND);
  assign io_bus.byte_tx_data  = r_byte_tx_data;
  assign io_bus.byte_tx_valid = r_byte_tx_valid;
  assign io_bus.rx_data       = r_rx_data;
  assign io_bus.rx_wren       = r_rx_wren;
  assign io_bus.rx_overrun    = r_rx_overrun;
  assign io_bus.dbg_tx_state  = r_tx_state;
  assign io_bus.dbg_rx_cnt    = r_rx_cnt;
endmodule
